// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: loads the program file into instruction memory, then walks pc through it
// and hands each word to decode over a valid/ready handshake, honouring branch redirects.
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned MEM_DEPTH = 400,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_fin_file,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic               mem_read_file,
    output logic               mem_read_mem,
    output logic [ADDR_W-1:0]  mem_pos,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  prog_len,
    output logic               done,
    output logic               fetch_err
);

    localparam int unsigned       ADDR_W1 = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LEN_CAP = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    len_q, len_d;
    logic [INSTR_W-1:0]   out_q, out_d;
    logic [ADDR_W-1:0]    ipc_q, ipc_d;
    logic                 err_q, err_d;
    logic                 load_strobe;
    logic [ADDR_W1-1:0]   pc_inc;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            pc_q    <= PC_INIT;
            len_q   <= '0;
            out_q   <= '0;
            ipc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            out_q   <= out_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the length cap also silences the file strobe
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        out_d       = out_q;
        ipc_d       = ipc_q;
        err_d       = err_q;
        load_strobe = (state_q == S_LOAD) && !mem_fin_file && (len_q < LEN_CAP);
        pc_inc      = {1'b0, pc_q} + ADDR_W1'(1);

        case (state_q)
            S_LOAD: begin
                if (load_strobe) begin
                    len_d = len_q + ADDR_W'(1);
                end
                if (mem_fin_file) begin
                    state_d = S_ISSUE;
                end else if (len_q >= LEN_CAP) begin
                    err_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                out_d   = mem_instr;
                ipc_d   = pc_q;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (instr_ready) begin
                    pc_d    = pc_inc[ADDR_W-1:0];
                    state_d = (pc_inc >= {1'b0, len_q}) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        // Redirect overrides the advance and drops whatever is in flight
        if (branch_en && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_VALID)) begin
            out_d = out_q;
            ipc_d = ipc_q;
            if (branch_target >= len_q) begin
                err_d   = 1'b1;
                pc_d    = pc_q;
                state_d = S_DONE;
            end else begin
                pc_d    = branch_target;
                state_d = S_ISSUE;
            end
        end
    end

    assign mem_read_file = load_strobe;
    assign mem_read_mem  = (state_q == S_ISSUE);
    assign mem_pos       = pc_q;
    assign instr_out     = out_q;
    assign instr_pc      = ipc_q;
    assign instr_valid   = (state_q == S_VALID);
    assign prog_len      = len_q;
    assign done          = (state_q == S_DONE);
    assign fetch_err     = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: file-backed memory model, cycle table for the basic walk,
// directed corner sequences and a randomized run against a transaction-level reference.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_fin_file;
    logic [15:0] mem_instr;
    logic        mem_read_file;
    logic        mem_read_mem;
    logic [8:0]  mem_pos;
    logic [15:0] instr_out;
    logic [8:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_en;
    logic [8:0]  branch_target;
    logic [8:0]  prog_len;
    logic        done;
    logic        fetch_err;

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_fin_file (mem_fin_file),
        .mem_instr    (mem_instr),
        .mem_read_file(mem_read_file),
        .mem_read_mem (mem_read_mem),
        .mem_pos      (mem_pos),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .prog_len     (prog_len),
        .done         (done),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // File + instruction memory model
    logic [15:0] prog [0:1023];
    int n_lines;
    int lines;
    int file_writes;
    int late_writes;

    assign mem_fin_file = (lines >= n_lines);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lines       <= 0;
            file_writes <= 0;
            late_writes <= 0;
            mem_instr   <= 16'h0;
        end else begin
            if (mem_read_file) begin
                lines       <= lines + 1;
                file_writes <= file_writes + 1;
                if (mem_fin_file) late_writes <= late_writes + 1;
            end
            if (mem_read_mem) mem_instr <= prog[mem_pos];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        instr_ready = 1'b0;
        branch_en = 1'b0;
        branch_target = 9'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < budget);
        if (!instr_valid) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_base4();
        prog[0] = 16'h1111;
        prog[1] = 16'h2222;
        prog[2] = 16'h3333;
        prog[3] = 16'h4444;
        n_lines = 4;
    endtask

    typedef struct {
        logic        rdy;
        logic        e_valid;
        logic        e_rm;
        logic [8:0]  e_pos;
        logic [15:0] e_instr;
        logic [8:0]  e_ipc;
        logic        e_done;
    } vec_t;

    function automatic vec_t mk(int rdy, int v, int rm, int pos, int ins, int ipc, int dn);
        vec_t r;
        r.rdy     = 1'(rdy);
        r.e_valid = 1'(v);
        r.e_rm    = 1'(rm);
        r.e_pos   = 9'(pos);
        r.e_instr = 16'(ins);
        r.e_ipc   = 9'(ipc);
        r.e_done  = 1'(dn);
        return r;
    endfunction

    vec_t tv [14];

    initial begin
        int n;
        int len;
        int exp_pc;
        int k;
        int tgt;
        logic exp_done;
        logic exp_err;

        tv[0]  = mk(1, 0, 1, 0, 0,      0, 0);
        tv[1]  = mk(1, 0, 0, 0, 0,      0, 0);
        tv[2]  = mk(1, 1, 0, 0, 'h1111, 0, 0);
        tv[3]  = mk(1, 0, 1, 1, 0,      0, 0);
        tv[4]  = mk(1, 0, 0, 0, 0,      0, 0);
        tv[5]  = mk(1, 1, 0, 0, 'h2222, 1, 0);
        tv[6]  = mk(1, 0, 1, 2, 0,      0, 0);
        tv[7]  = mk(1, 0, 0, 0, 0,      0, 0);
        tv[8]  = mk(1, 1, 0, 0, 'h3333, 2, 0);
        tv[9]  = mk(1, 0, 1, 3, 0,      0, 0);
        tv[10] = mk(1, 0, 0, 0, 0,      0, 0);
        tv[11] = mk(1, 1, 0, 0, 'h4444, 3, 0);
        tv[12] = mk(1, 0, 0, 0, 0,      0, 1);
        tv[13] = mk(1, 0, 0, 0, 0,      0, 1);

        // Reset values and basic walk
        load_base4();
        rst = 1'b0;
        instr_ready = 1'b0;
        branch_en = 1'b0;
        branch_target = 9'd0;
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_len", 32'(prog_len), 32'd0);
        check("rst_instr", 32'(instr_out), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        check("rst_rm", 32'(mem_read_mem), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        instr_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read_mem && n < 50);
        check("t1_len", 32'(prog_len), 32'd4);
        check("t1_writes", 32'(file_writes), 32'd4);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            instr_ready = tv[i].rdy;
            check($sformatf("t1_valid[%0d]", i), 32'(instr_valid), 32'(tv[i].e_valid));
            check($sformatf("t1_rm[%0d]", i), 32'(mem_read_mem), 32'(tv[i].e_rm));
            check($sformatf("t1_done[%0d]", i), 32'(done), 32'(tv[i].e_done));
            if (tv[i].e_rm) check($sformatf("t1_pos[%0d]", i), 32'(mem_pos), 32'(tv[i].e_pos));
            if (tv[i].e_valid) begin
                check($sformatf("t1_instr[%0d]", i), 32'(instr_out), 32'(tv[i].e_instr));
                check($sformatf("t1_ipc[%0d]", i), 32'(instr_pc), 32'(tv[i].e_ipc));
            end
        end
        check("t1_err", 32'(fetch_err), 32'd0);

        // Stall on word 1
        do_reset();
        wait_valid(50);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("t2_instr", 32'(instr_out), 32'h2222);
            check("t2_ipc", 32'(instr_pc), 32'd1);
            check("t2_valid", 32'(instr_valid), 32'd1);
            check("t2_rm", 32'(mem_read_mem), 32'd0);
            @(negedge clk);
        end
        check("t2_held", 32'(instr_ipc_pair()), 32'h00012222);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t2_after_valid", 32'(instr_valid), 32'd0);
        check("t2_after_rm", 32'(mem_read_mem), 32'd1);
        check("t2_after_pos", 32'(mem_pos), 32'd2);

        // Branch back to 0 on the handshake of word 2
        do_reset();
        for (int w = 0; w < 3; w++) begin
            wait_valid(50);
            check("t3_ipc", 32'(instr_pc), 32'(w));
            if (w == 2) begin
                branch_en = 1'b1;
                branch_target = 9'd0;
            end
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            branch_en = 1'b0;
        end
        check("t3_rm", 32'(mem_read_mem), 32'd1);
        check("t3_pos", 32'(mem_pos), 32'd0);
        wait_valid(20);
        check("t3_instr", 32'(instr_out), 32'h1111);
        check("t3_ipc0", 32'(instr_pc), 32'd0);

        // Branch while waiting on pc 1
        do_reset();
        wait_valid(50);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t4_issue_pos", 32'(mem_pos), 32'd1);
        @(negedge clk);
        check("t4_wait_rm", 32'(mem_read_mem), 32'd0);
        check("t4_wait_valid", 32'(instr_valid), 32'd0);
        branch_en = 1'b1;
        branch_target = 9'd3;
        @(negedge clk);
        branch_en = 1'b0;
        check("t4_valid_dropped", 32'(instr_valid), 32'd0);
        check("t4_rm", 32'(mem_read_mem), 32'd1);
        check("t4_pos", 32'(mem_pos), 32'd3);
        wait_valid(20);
        check("t4_ipc", 32'(instr_pc), 32'd3);
        check("t4_instr", 32'(instr_out), 32'h4444);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t4_done", 32'(done), 32'd1);
        check("t4_err", 32'(fetch_err), 32'd0);

        // Out-of-range target
        do_reset();
        wait_valid(50);
        branch_en = 1'b1;
        branch_target = 9'd7;
        @(negedge clk);
        branch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_err", 32'(fetch_err), 32'd1);
            check("t5_done", 32'(done), 32'd1);
            check("t5_valid", 32'(instr_valid), 32'd0);
            check("t5_strobes", 32'({mem_read_file, mem_read_mem}), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset during VALID, then reload a longer file
        do_reset();
        wait_valid(50);
        #2 rst = 1'b0;
        #1;
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_instr", 32'(instr_out), 32'd0);
        check("t6_ipc", 32'(instr_pc), 32'd0);
        check("t6_len", 32'(prog_len), 32'd0);
        check("t6_pos", 32'(mem_pos), 32'd0);
        check("t6_flags", 32'({done, fetch_err, mem_read_mem}), 32'd0);
        prog[4] = 16'h5555;
        prog[5] = 16'h6666;
        n_lines = 6;
        @(negedge clk);
        rst = 1'b1;
        wait_valid(50);
        check("t6_len_re", 32'(prog_len), 32'd6);
        check("t6_writes", 32'(file_writes), 32'd6);
        check("t6_late", 32'(late_writes), 32'd0);
        check("t6_instr_re", 32'(instr_out), 32'h1111);

        // Load runs into the depth cap
        for (int i = 0; i < 400; i++) prog[i] = 16'($urandom);
        n_lines = 1000;
        do_reset();
        wait_valid(1000);
        check("cap_len", 32'(prog_len), 32'd400);
        check("cap_err", 32'(fetch_err), 32'd1);
        check("cap_writes", 32'(file_writes), 32'd400);
        check("cap_done", 32'(done), 32'd0);
        branch_en = 1'b1;
        branch_target = 9'd399;
        @(negedge clk);
        branch_en = 1'b0;
        wait_valid(20);
        check("cap_ipc", 32'(instr_pc), 32'd399);
        check("cap_instr", 32'(instr_out), 32'(prog[399]));
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("cap_end", 32'(done), 32'd1);

        // Randomized programs against the transaction-level reference
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) prog[i] = 16'($urandom);
            n_lines = len;
            do_reset();
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_read_mem && n < 50);
            check("rnd_len", 32'(prog_len), 32'(len));
            exp_pc = 0;
            exp_done = 1'b0;
            exp_err = 1'b0;
            k = 2;
            n = 0;
            while (n < 300) begin
                check("rnd_excl", 32'(mem_read_file & mem_read_mem), 32'd0);
                if (exp_done) begin
                    check("rnd_done", 32'(done), 32'd1);
                    check("rnd_done_valid", 32'(instr_valid), 32'd0);
                    check("rnd_done_err", 32'(fetch_err), 32'(exp_err));
                    break;
                end
                if (k > 0) begin
                    check("rnd_gap_valid", 32'(instr_valid), 32'd0);
                    if (k == 2) check("rnd_issue_pos", 32'({mem_read_mem, mem_pos}), 32'({1'b1, 9'(exp_pc)}));
                    k--;
                    branch_en = 1'b0;
                    instr_ready = 1'($urandom);
                end else begin
                    check("rnd_valid", 32'(instr_valid), 32'd1);
                    check("rnd_ipc", 32'(instr_pc), 32'(exp_pc));
                    check("rnd_instr", 32'(instr_out), 32'(prog[exp_pc]));
                    branch_en = ($urandom_range(0, 4) == 0);
                    instr_ready = 1'($urandom);
                    tgt = $urandom_range(0, len + 1);
                    branch_target = 9'(tgt);
                    if (branch_en) begin
                        if (tgt >= len) begin
                            exp_done = 1'b1;
                            exp_err = 1'b1;
                        end else begin
                            exp_pc = tgt;
                            k = 2;
                        end
                    end else if (instr_ready) begin
                        exp_pc++;
                        if (exp_pc >= len) exp_done = 1'b1;
                        else k = 2;
                    end
                end
                @(negedge clk);
                n++;
            end
            branch_en = 1'b0;
            if (n >= 300) check("rnd_no_finish", 32'd0, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] instr_ipc_pair();
        return {7'd0, instr_pc, instr_out};
    endfunction

endmodule
